// File: rtl/genius_pkg.sv
// Shared definitions for the Genius game controller and datapath: state
// encodings, the debounce default and the per-state strobe decode.
package genius_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

    typedef enum logic [3:0] {
        INIT       = 4'd0,
        SETUP      = 4'd1,
        SEQUENCE   = 4'd2,
        PREP       = 4'd3,
        USER_PLAY  = 4'd4,
        USER_LATCH = 4'd5,
        CHECK      = 4'd6,
        NEXT_ROUND = 4'd7,
        RESULT     = 4'd8
    } state_e;

    typedef struct packed {
        logic r1;
        logic r2;
        logic e1;
        logic e2;
        logic e3;
        logic e4;
        logic sel;
    } strobes_t;

    // Moore decode: anything not named for a state stays low.
    function automatic strobes_t strobes_for(input state_e s);
        strobes_t o;
        o = '0;
        case (s)
            INIT:       begin o.r1 = 1'b1; o.r2 = 1'b1; end
            SETUP:      o.e1 = 1'b1;
            SEQUENCE:   o.e3 = 1'b1;
            PREP:       o.r2 = 1'b1;
            USER_PLAY:  o.e2 = 1'b1;
            USER_LATCH: begin o.e2 = 1'b1; o.e4 = 1'b1; end
            CHECK:      o.e2 = 1'b1;
            RESULT:     o.sel = 1'b1;
            default:    o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/genius_controller_if.sv
// Controller <-> datapath bundle: status levels from the datapath, control
// strobes to it. The controller is the master side.
interface genius_controller_if;
    logic end_FPGA;
    logic end_User;
    logic end_time;
    logic win;
    logic match;
    logic R1;
    logic R2;
    logic E1;
    logic E2;
    logic E3;
    logic E4;
    logic SEL;

    modport master (
        input  end_FPGA, end_User, end_time, win, match,
        output R1, R2, E1, E2, E3, E4, SEL
    );

    modport slave (
        output end_FPGA, end_User, end_time, win, match,
        input  R1, R2, E1, E2, E3, E4, SEL
    );
endinterface

// File: rtl/genius_controller_key_pulse.sv
// ENTER conditioning: 2-FF synchronizer, stable-low counter and a single
// registered pulse once the key has been low for DEBOUNCE_CYCLES samples.
module key_pulse
    import genius_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pulse
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ARM = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;

    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        // Saturating at CNT_MAX keeps a held key from firing again.
        if (sync2_q)
            cnt_d = '0;
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
        else
            cnt_d = cnt_q;
        pulse_d = !sync2_q && (cnt_q == CNT_ARM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;
endmodule

// File: rtl/genius_controller.sv
// Genius (Simon) game control FSM: sequences the datapath through setup,
// playback, user entry and result, driven by a debounced ENTER key.
module genius_controller
    import genius_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned p_state         = 4
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_N,
    input  logic                 ENTER,
    genius_controller_if.master  dp,
    output logic [p_state-1:0]   state
);
    logic     enter_pulse;
    state_e   state_q, state_d;
    strobes_t out_q, out_d;

    key_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_pulse (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .key_n (ENTER),
        .pulse (enter_pulse)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:       state_d = SETUP;
            SETUP:      if (enter_pulse) state_d = SEQUENCE;
            SEQUENCE:   if (dp.end_FPGA) state_d = PREP;
            PREP:       state_d = USER_PLAY;
            USER_PLAY: begin
                if (dp.end_time)     state_d = RESULT;
                else if (enter_pulse) state_d = USER_LATCH;
            end
            USER_LATCH: state_d = CHECK;
            CHECK: begin
                if (dp.end_time)      state_d = RESULT;
                else if (!dp.match)   state_d = RESULT;
                else if (dp.end_User) state_d = NEXT_ROUND;
                else                  state_d = USER_PLAY;
            end
            NEXT_ROUND: state_d = dp.win ? RESULT : SEQUENCE;
            RESULT:     if (enter_pulse) state_d = INIT;
            default:    state_d = INIT;
        endcase
        // Strobes are registered from the next state so they line up with state_q.
        out_d = strobes_for(state_d);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= INIT;
            out_q   <= strobes_for(INIT);
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign dp.R1  = out_q.r1;
    assign dp.R2  = out_q.r2;
    assign dp.E1  = out_q.e1;
    assign dp.E2  = out_q.e2;
    assign dp.E3  = out_q.e3;
    assign dp.E4  = out_q.e4;
    assign dp.SEL = out_q.sel;
    assign state  = p_state'(state_q);
endmodule

// File: doc/genius_controller.md
Name: genius_controller

Overview:
- Control FSM for the Genius (Simon) game; the counterpart that consumes the datapath's status flags (end_FPGA, end_User, end_time, win, match).
- Drives the datapath control strobes R1, R2, E1–E4 and SEL.
- Conditions the ENTER push-button (KEY, active-low) into a debounced one-cycle pulse.
- Sits at top level beside the datapath; both run on CLOCK_50.

Parameters:
- DEBOUNCE_CYCLES, 500000, stable-low cycles required before ENTER is accepted (10 ms at 50 MHz); min 2.
- p_state, 4, width of the state debug output.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- RESET_N  in  1  asynchronous active-low reset
- ENTER  in  1  raw push-button, active-low, asynchronous
- end_FPGA  in  1  datapath: FPGA finished showing the current sequence
- end_User  in  1  datapath: user entered the full sequence for this round
- end_time  in  1  datapath: user time limit expired
- win  in  1  datapath: final round completed
- match  in  1  datapath: last user entry equals expected element
- R1  out  1  datapath game reset (rounds, sequence index, setup)
- R2  out  1  datapath round reset (timer, user index)
- E1  out  1  load setup register
- E2  out  1  enable time counter
- E3  out  1  enable FPGA sequence playback
- E4  out  1  one-cycle user-entry latch
- SEL  out  1  hex display select: 0 = game/setup view, 1 = result view
- state  out  p_state  current state encoding, debug

Behaviour:
- One clock domain; only RESET_N is asynchronous, active-low.
- Reset: state=INIT, debounce counter=0, sync FFs=1 (key released).
- ENTER conditioning:
  - ENTER passes a 2-FF synchronizer.
  - Counter increments while the synced level is 0 and clears when it is 1.
  - enter_pulse is high for exactly one cycle when the counter reaches DEBOUNCE_CYCLES; it saturates there, so a held key yields one pulse.
  - Total latency from ENTER falling (held low) to enter_pulse = DEBOUNCE_CYCLES+2 cycles.
- States and encodings: INIT=0, SETUP=1, SEQUENCE=2, PREP=3, USER_PLAY=4, USER_LATCH=5, CHECK=6, NEXT_ROUND=7, RESULT=8. Unused encodings go to INIT.
- Outputs are Moore, decoded from the state register; every strobe not listed for a state is 0.
  - INIT: R1=1, R2=1. Outputs are therefore R1=R2=1, all others 0, while in reset. Next state SETUP unconditionally.
  - SETUP: E1=1. Leave on enter_pulse -> SEQUENCE.
  - SEQUENCE: E3=1. Leave on end_FPGA -> PREP.
  - PREP: R2=1 for one cycle. Next state USER_PLAY.
  - USER_PLAY: E2=1. Priority: end_time -> RESULT; else enter_pulse -> USER_LATCH.
  - USER_LATCH: E2=1, E4=1 for exactly one cycle. Next state CHECK.
  - CHECK: E2=1. Priority: end_time -> RESULT; !match -> RESULT; end_User -> NEXT_ROUND; else -> USER_PLAY.
  - NEXT_ROUND: no strobes. win -> RESULT; else -> SEQUENCE.
  - RESULT: SEL=1. enter_pulse -> INIT.
- Status inputs are sampled as levels; they are not required to be pulses. In CHECK they are the values the datapath produces after the E4 latch edge.
- enter_pulse is ignored in SEQUENCE, PREP, USER_LATCH, CHECK and NEXT_ROUND; there is no queuing.
- RESET_N low in any state forces INIT immediately, with no wait for a clock edge.

Decomposition:
- Shared package genius_pkg holds the state encoding constants (INIT..RESULT) and the DEBOUNCE_CYCLES default; the datapath bench uses the same package.
- One sub-module, key_pulse: synchronizer + debounce counter + single-pulse generator, parameterised by DEBOUNCE_CYCLES.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: RESET_N=0 mid-USER_PLAY -> state=0, R1=R2=1 combinationally after the reset edge; release -> SETUP next cycle, E1=1.
- Debounce: ENTER low 3 cycles then high -> no pulse. ENTER held low 20 cycles -> exactly one enter_pulse, 6 cycles after the falling edge; SETUP->SEQUENCE.
- Correct round: end_FPGA=1 -> PREP (R2 one cycle) -> USER_PLAY. ENTER with match=1, end_User=1, win=0 -> E4 one cycle, then NEXT_ROUND, then SEQUENCE.
- Wrong entry: in USER_PLAY press ENTER with match=0 -> USER_LATCH, CHECK, RESULT; SEL=1. ENTER again -> INIT, then SETUP.
- Timeout priority: end_time=1 in the same cycle as enter_pulse in USER_PLAY -> RESULT; E4 never asserted.
- Win: CHECK with match=1, end_User=1 -> NEXT_ROUND with win=1 -> RESULT, SEL=1; E3 not re-asserted.
